// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared pipeline defines: opcode and ALU encodings used across the core,
// the hazard-controller FSM state type and scoreboard sizing defaults.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    // Base ISA major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU operation select
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    // Hazard controller sizing
    localparam int PEND_W_DEF = 2;   // per-register in-flight write counter width
    localparam int NUM_REGS   = 32;
    localparam int REG_AW     = 5;

    // Hazard controller FSM
    typedef enum logic [1:0] {
        ST_RUN,     // normal issue
        ST_FLUSH,   // one cycle killing the wrong-path fetch
        ST_DRAIN,   // ebreak issued, waiting for all writes to retire
        ST_HALT     // stopped until reset
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hz_scoreboard.sv
// -----------------------------------------------------------------------------
// hz_scoreboard
// 32-entry table of PEND_W-bit in-flight write counters. Entry 0 (x0) is
// always zero.
// Ports:
//   clk, rst_n        clock; rst_n is an asynchronous ACTIVE-HIGH reset
//   rd_addr_a/b       read port addresses -> rd_cnt_a/b counts
//   inc_en, inc_addr  increment port; inc_full flags the target as saturated
//                     (a saturated increment is dropped)
//   dec_en, dec_addr  decrement port; ignored for x0 or a zero count
//   drained_next      every counter will be zero after this cycle's update
// -----------------------------------------------------------------------------
module hz_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [PEND_W-1:0] rd_cnt_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [PEND_W-1:0] rd_cnt_b,
    input  logic              inc_en,
    input  logic [REG_AW-1:0] inc_addr,
    output logic              inc_full,
    input  logic              dec_en,
    input  logic [REG_AW-1:0] dec_addr,
    output logic              drained_next
);

    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

    logic [PEND_W-1:0] cnt_q [NUM_REGS];
    logic [PEND_W-1:0] cnt_d [NUM_REGS];
    logic              inc_hit;
    logic              dec_hit;
    logic              any_pending;

    always_comb begin
        // NOTE: every output of this block gets a value before any branch, so
        // no path leaves a signal holding its old value (no latch inferred).
        rd_cnt_a = cnt_q[rd_addr_a];
        rd_cnt_b = cnt_q[rd_addr_b];
        inc_full = (cnt_q[inc_addr] == CNT_MAX);
        inc_hit  = inc_en && (inc_addr != '0) && !inc_full;
        dec_hit  = dec_en && (dec_addr != '0) && (cnt_q[dec_addr] != '0);

        cnt_d = cnt_q;
        // Issue and retire to the same register cancel out.
        if (!(inc_hit && dec_hit && (inc_addr == dec_addr))) begin
            if (dec_hit) cnt_d[dec_addr] = cnt_q[dec_addr] - PEND_W'(1);
            if (inc_hit) cnt_d[inc_addr] = cnt_q[inc_addr] + PEND_W'(1);
        end
        cnt_d[0] = '0;

        any_pending = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            any_pending = any_pending | (cnt_d[i] != '0);
        end
        drained_next = !any_pending;
    end

    // NOTE: this table is reset, unlike a data RAM: "nothing in flight" is
    // architectural state, and stale counts after reset would stall forever.
    always_ff @(posedge clk or posedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Scoreboard-based issue control for an in-order pipeline: RAW and WAW
// (counter saturation) stalls at ID, a one-cycle fetch flush after taken
// jumps, and an ebreak drain-then-halt sequence.
// Configuration macro: HAZARD_FORWARD_EN -- when defined only loads are
// tracked (ALU results are covered by EX/MEM forwarding); when undefined
// every register writer is tracked.
// Ports:
//   clk                       rising-edge clock
//   rst_n                     asynchronous ACTIVE-HIGH reset (1 = reset)
//   id_valid                  ID holds a valid instruction
//   id_rs1/2, id_rs1/2_used   source indices and whether they are read
//   id_rd, id_rd_wen          destination and write intent
//   id_is_load                ID instruction is a load
//   id_is_jump, id_ebreak     taken branch/jal/jalr, ebreak
//   wb_rdid, wb_wren          writeback retire port
//   id_stall, id_fire         hold IF/ID, instruction issues this cycle
//   if_flush, halted          kill wrong-path fetch, core stopped
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_wen,
    input  logic              id_is_load,
    input  logic              id_is_jump,
    input  logic              id_ebreak,
    input  logic [REG_AW-1:0] wb_rdid,
    input  logic              wb_wren,
    output logic              id_stall,
    output logic              id_fire,
    output logic              if_flush,
    output logic              halted
);

    hz_state_e         state_q;
    logic              if_flush_q;
    logic              halted_q;

    logic [PEND_W-1:0] cnt_rs1;
    logic [PEND_W-1:0] cnt_rs2;
    logic              rd_full;
    logic              drained_next;

    logic              rd_tracked;
    logic              hazard;
    logic              structural;
    logic              in_run;
    logic              track_gate;
    logic              inc_en;

`ifdef HAZARD_FORWARD_EN
    assign track_gate = id_is_load;
`else
    logic unused_is_load;
    assign unused_is_load = id_is_load;
    assign track_gate     = 1'b1;
`endif

    hz_scoreboard #(
        .PEND_W       (PEND_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_a    (id_rs1),
        .rd_cnt_a     (cnt_rs1),
        .rd_addr_b    (id_rs2),
        .rd_cnt_b     (cnt_rs2),
        .inc_en       (inc_en),
        .inc_addr     (id_rd),
        .inc_full     (rd_full),
        .dec_en       (wb_wren),
        .dec_addr     (wb_rdid),
        .drained_next (drained_next)
    );

    always_comb begin
        rd_tracked = id_rd_wen && (id_rd != '0);
        hazard     = (id_rs1_used && (cnt_rs1 != '0)) ||
                     (id_rs2_used && (cnt_rs2 != '0));
        // A saturated counter cannot record another in-flight write.
        structural = rd_tracked && rd_full;
        // Outputs are forced low while reset is held, independent of clk.
        in_run     = !rst_n && (state_q == ST_RUN);

        id_stall   = (in_run && id_valid && (hazard || structural)) ||
                     (!rst_n && ((state_q == ST_DRAIN) || (state_q == ST_HALT)));
        id_fire    = in_run && id_valid && !(hazard || structural);
        inc_en     = id_fire && rd_tracked && track_gate;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= ST_RUN;
            if_flush_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // ebreak wins over a simultaneous jump.
                    if (id_fire && id_ebreak) begin
                        state_q <= ST_DRAIN;
                    end else if (id_fire && id_is_jump) begin
                        state_q    <= ST_FLUSH;
                        if_flush_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state_q    <= ST_RUN;
                    if_flush_q <= 1'b0;
                end
                ST_DRAIN: begin
                    // Look at post-update counts so halt follows the last retire
                    // by exactly one cycle.
                    if (drained_next) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q    <= ST_RUN;
                    if_flush_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign if_flush = if_flush_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model: an integer count per register plus three mode flags.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int PEND_W  = 2;
    localparam int CNT_MAX = (1 << PEND_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd, wb_rdid;
    logic       id_rs1_used, id_rs2_used, id_rd_wen, id_is_load;
    logic       id_is_jump, id_ebreak, wb_wren;
    logic       id_stall, id_fire, if_flush, halted;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.PEND_W(PEND_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rd_wen   (id_rd_wen),
        .id_is_load  (id_is_load),
        .id_is_jump  (id_is_jump),
        .id_ebreak   (id_ebreak),
        .wb_rdid     (wb_rdid),
        .wb_wren     (wb_wren),
        .id_stall    (id_stall),
        .id_fire     (id_fire),
        .if_flush    (if_flush),
        .halted      (halted)
    );

    // Reference model
    int m_cnt [32];
    bit m_flush, m_drain, m_halt;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic bit m_blocked();
        bit haz, str;
        haz = (id_rs1_used && m_cnt[id_rs1] != 0) || (id_rs2_used && m_cnt[id_rs2] != 0);
        str = id_rd_wen && id_rd != 0 && m_cnt[id_rd] == CNT_MAX;
        return haz || str;
    endfunction

    function automatic bit m_tracked();
`ifdef HAZARD_FORWARD_EN
        return id_rd_wen && id_rd != 0 && id_is_load;
`else
        return id_rd_wen && id_rd != 0;
`endif
    endfunction

    function automatic bit m_run();
        return !m_flush && !m_drain && !m_halt;
    endfunction

    function automatic bit exp_fire();
        return m_run() && id_valid && !m_blocked();
    endfunction

    function automatic bit exp_stall();
        return (m_run() && id_valid && m_blocked()) || m_drain || m_halt;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Compare all outputs against the model mid-cycle.
    task automatic eval(input string tag);
        @(negedge clk);
        check($sformatf("%s.stall", tag),  id_stall, exp_stall());
        check($sformatf("%s.fire", tag),   id_fire,  exp_fire());
        check($sformatf("%s.flush", tag),  if_flush, m_flush);
        check($sformatf("%s.halted", tag), halted,   m_halt);
    endtask

    // Clock edge: advance the model with the inputs that were present.
    task automatic adv();
        bit fire, tracked, all_zero;
        @(posedge clk);
        fire    = exp_fire();
        tracked = m_tracked();
        if (wb_wren && wb_rdid != 0 && m_cnt[wb_rdid] > 0) m_cnt[wb_rdid]--;
        if (fire && tracked) m_cnt[id_rd]++;
        if (m_flush) begin
            m_flush = 0;
        end else if (m_drain) begin
            all_zero = 1;
            foreach (m_cnt[i]) if (m_cnt[i] != 0) all_zero = 0;
            if (all_zero) begin
                m_drain = 0;
                m_halt  = 1;
            end
        end else if (!m_halt && fire) begin
            if (id_ebreak)       m_drain = 1;
            else if (id_is_jump) m_flush = 1;
        end
        #1;
    endtask

    task automatic step(input string tag);
        eval(tag);
        adv();
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_wen = 0; id_is_load = 0; id_is_jump = 0; id_ebreak = 0;
        wb_rdid = 0; wb_wren = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic wen,
                         input logic ld, input logic jmp, input logic ebk);
        id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_rd_wen = wen; id_is_load = ld; id_is_jump = jmp; id_ebreak = ebk;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd);
        wb_wren = en;
        wb_rdid = rd;
    endtask

    // Called just after a rising edge; holds reset across one edge.
    task automatic do_reset();
        rst_n = 1;
        #2;
        check("rst.stall",  id_stall, 1'b0);
        check("rst.fire",   id_fire,  1'b0);
        check("rst.flush",  if_flush, 1'b0);
        check("rst.halted", halted,   1'b0);
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_flush = 0; m_drain = 0; m_halt = 0;
        @(posedge clk);
        #1;
        rst_n = 0;
    endtask

    initial begin
        set_idle();
        rst_n = 1;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_flush = 0; m_drain = 0; m_halt = 0;
        @(posedge clk);
        #1;
        do_reset();
        step("idle");

`ifndef HAZARD_FORWARD_EN
        // RAW: addi x5 then add x6,x5,x1
        do_reset();
        issue(0, 1, 0, 0, 5, 1, 0, 0, 0);
        eval("raw.addi"); check("raw.addi_fire", id_fire, 1'b1); adv();
        issue(5, 1, 1, 1, 6, 1, 0, 0, 0);
        eval("raw.use0"); check("raw.stall0", id_stall, 1'b1); adv();
        eval("raw.use1"); check("raw.stall1", id_stall, 1'b1); adv();
        set_wb(1, 5);
        eval("raw.wb");   check("raw.stall_wb", id_stall, 1'b1); adv();
        set_wb(0, 0);
        eval("raw.go");   check("raw.fire", id_fire, 1'b1); adv();
        set_idle();
`else
        // Load-use: ld x7 then addi x8,x7,1; addi x9 then use of x9
        do_reset();
        issue(1, 1, 0, 0, 7, 1, 1, 0, 0);
        eval("lu.ld");    check("lu.ld_fire", id_fire, 1'b1); adv();
        issue(7, 1, 0, 0, 8, 1, 0, 0, 0);
        eval("lu.use0");  check("lu.stall0", id_stall, 1'b1); adv();
        set_wb(1, 7);
        eval("lu.wb");    check("lu.stall_wb", id_stall, 1'b1); adv();
        set_wb(0, 0);
        eval("lu.go");    check("lu.fire", id_fire, 1'b1); adv();
        issue(0, 1, 0, 0, 9, 1, 0, 0, 0);
        eval("lu.alu");   check("lu.alu_fire", id_fire, 1'b1); adv();
        issue(9, 1, 9, 1, 10, 1, 0, 0, 0);
        eval("lu.fwd");   check("lu.fwd_nostall", id_stall, 1'b0); adv();
        set_idle();
`endif

        // Jump flush: jal x1, then one flush cycle
        do_reset();
        issue(0, 0, 0, 0, 1, 1, 0, 1, 0);
        eval("jmp.jal");  check("jmp.jal_fire", id_fire, 1'b1); adv();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval("jmp.fl");   check("jmp.flush1", if_flush, 1'b1); check("jmp.fire0", id_fire, 1'b0); adv();
        eval("jmp.run");  check("jmp.flush0", if_flush, 1'b0); check("jmp.fire1", id_fire, 1'b1); adv();

        // Reset while in FLUSH
        issue(0, 0, 0, 0, 2, 1, 0, 1, 0);
        eval("jmp2.jal"); adv();
        do_reset();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval("jmp2.post"); check("jmp2.flush0", if_flush, 1'b0); check("jmp2.fire", id_fire, 1'b1); adv();

        // WAW saturation on x3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, 0, 0, 3, 1, 1, 0, 0);
            eval("waw.w"); check($sformatf("waw.w%0d_fire", i), id_fire, 1'b1); adv();
        end
        eval("waw.full"); check("waw.struct", id_stall, 1'b1); adv();
        set_wb(1, 3);
        eval("waw.wb");   check("waw.struct_wb", id_stall, 1'b1); adv();
        set_wb(0, 0);
        eval("waw.go");   check("waw.fire4", id_fire, 1'b1); adv();
        set_idle();

        // x0 writes never stall; same-cycle issue/retire on x4
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(0, 1, 0, 1, 0, 1, 1, 0, 0);
            eval("x0.w"); check($sformatf("x0.w%0d_fire", i), id_fire, 1'b1); adv();
        end
        issue(0, 0, 0, 0, 4, 1, 1, 0, 0);
        eval("sc.ld1");  check("sc.ld1_fire", id_fire, 1'b1); adv();
        set_wb(1, 4);
        eval("sc.both"); check("sc.both_fire", id_fire, 1'b1); adv();
        set_wb(0, 0);
        issue(4, 1, 0, 0, 0, 0, 0, 0, 0);
        eval("sc.rd0");  check("sc.pending", id_stall, 1'b1); adv();
        set_wb(1, 4);
        eval("sc.wb");   check("sc.pending_wb", id_stall, 1'b1); adv();
        set_wb(0, 0);
        eval("sc.go");   check("sc.cnt_was_1", id_fire, 1'b1); adv();

        // ebreak with two pending loads
        do_reset();
        issue(0, 0, 0, 0, 10, 1, 1, 0, 0); step("ebk.ld10");
        issue(0, 0, 0, 0, 11, 1, 1, 0, 0); step("ebk.ld11");
        issue(0, 0, 0, 0, 0, 0, 0, 1, 1);
        eval("ebk.fire"); check("ebk.fire", id_fire, 1'b1); adv();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval("ebk.dr");   check("ebk.drain_stall", id_stall, 1'b1); check("ebk.drain_nohalt", halted, 1'b0); adv();
        set_wb(1, 10);
        eval("ebk.wb10"); check("ebk.wb10_stall", id_stall, 1'b1); adv();
        set_wb(1, 11);
        eval("ebk.wb11"); check("ebk.wb11_nohalt", halted, 1'b0); adv();
        set_wb(0, 0);
        eval("ebk.h");    check("ebk.halted", halted, 1'b1); check("ebk.h_stall", id_stall, 1'b1);
        check("ebk.h_fire", id_fire, 1'b0); adv();
        eval("ebk.h2");   check("ebk.halted2", halted, 1'b1); adv();
        do_reset();
        eval("ebk.rst");  check("ebk.rst_halted", halted, 1'b0); check("ebk.rst_fire", id_fire, 1'b1); adv();

        // Reset while in DRAIN
        issue(0, 0, 0, 0, 12, 1, 1, 0, 0); step("drn.ld");
        issue(0, 0, 0, 0, 0, 0, 0, 0, 1); step("drn.ebk");
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval("drn.in");   check("drn.in_stall", id_stall, 1'b1); adv();
        do_reset();
        eval("drn.post"); check("drn.post_stall", id_stall, 1'b0); check("drn.post_fire", id_fire, 1'b1); adv();

        // Randomized traffic on x0..x7
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ((m_halt && $urandom_range(0, 2) == 0) || $urandom_range(0, 199) == 0)
                do_reset();
            id_valid    = ($urandom_range(0, 9) < 7);
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            id_rd       = 5'($urandom_range(0, 7));
            id_rd_wen   = 1'($urandom_range(0, 1));
            id_is_load  = 1'($urandom_range(0, 1));
            id_is_jump  = ($urandom_range(0, 9) == 0);
            id_ebreak   = ($urandom_range(0, 39) == 0);
            wb_wren     = 1'($urandom_range(0, 1));
            wb_rdid     = 5'($urandom_range(0, 7));
            step($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
